// File: rtl/pdec_seq_if.sv
// Handshake bundle for pdec_seq: a code stream in, a merged one-hot word stream out.
interface pdec_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_none;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vec;
    logic [3:0] out_cnt;
    logic       out_err;

    modport master (
        output in_valid, in_code, in_none, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_cnt, out_err
    );

    modport slave (
        input  in_valid, in_code, in_none, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_cnt, out_err
    );
endinterface

// File: rtl/pdec_seq.sv
// Merges up to ACC_MAX encoded bit indices into one 8-bit vector word, flagging
// codes that hit an already-set bit; one word is presented at a time.
module pdec_seq #(
    parameter int ACC_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    pdec_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic [3:0] CNT_MAX = 4'(ACC_MAX);

    function automatic logic [7:0] decode(input logic [2:0] code, input logic none);
        return none ? 8'h00 : (8'h01 << code);
    endfunction

    state_t     state;
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       err;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [7:0] out_vec_r;
    logic [3:0] out_cnt_r;
    logic       out_err_r;

    logic       take;
    logic       close;
    logic [7:0] dec;
    logic [7:0] nmask;
    logic [3:0] ncnt;
    logic       nerr;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_vec   = out_vec_r;
    assign bus.out_cnt   = out_cnt_r;
    assign bus.out_err   = out_err_r;

    // Next accumulator contents if the current beat is taken; IDLE starts a fresh word.
    always_comb begin
        take = bus.in_valid && in_ready_r;
        dec  = decode(bus.in_code, bus.in_none);
        if (state == ACC) begin
            nmask = mask | dec;
            ncnt  = cnt + 4'd1;
            nerr  = err | (!bus.in_none && mask[bus.in_code]);
        end else begin
            nmask = dec;
            ncnt  = 4'd1;
            nerr  = 1'b0;
        end
        close = bus.in_last || (ncnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= 8'h00;
            cnt         <= 4'd0;
            err         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_vec_r   <= 8'h00;
            out_cnt_r   <= 4'd0;
            out_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (take) begin
                        mask <= nmask;
                        cnt  <= ncnt;
                        err  <= nerr;
                        if (close) begin
                            state       <= OUT;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_vec_r   <= nmask;
                            out_cnt_r   <= ncnt;
                            out_err_r   <= nerr;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                OUT: begin
                    // Output registers keep the word after the handshake.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdec_seq.sv
// Directed bench for pdec_seq: ACC_MAX=4 instance for word merging, ACC_MAX=1 for streaming.
module tb_pdec_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pdec_seq_if a ();
    pdec_seq_if b ();

    pdec_seq #(.ACC_MAX(4)) u0 (.clk(clk), .rst(rst), .bus(a.slave));
    pdec_seq #(.ACC_MAX(1)) u1 (.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] code, input logic none, input logic last);
        a.in_valid = 1'b1;
        a.in_code  = code;
        a.in_none  = none;
        a.in_last  = last;
        tick();
        a.in_valid = 1'b0;
        a.in_none  = 1'b0;
        a.in_last  = 1'b0;
    endtask

    task automatic consume();
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
    endtask

    initial begin
        a.in_valid = 1'b0; a.in_code = 3'd0; a.in_none = 1'b0; a.in_last = 1'b0;
        a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_code = 3'd0; b.in_none = 1'b0; b.in_last = 1'b0;
        b.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready",  8'(a.in_ready),  8'h01);
        check("rst_out_valid", 8'(a.out_valid), 8'h00);
        check("rst_out_vec",   a.out_vec,       8'h00);
        check("rst_out_cnt",   8'(a.out_cnt),   8'h00);
        check("rst_out_err",   8'(a.out_err),   8'h00);

        // Codes 3, 0, 7(last)
        beat(3'd3, 1'b0, 1'b0);
        beat(3'd0, 1'b0, 1'b0);
        check("w1_pre_valid", 8'(a.out_valid), 8'h00);
        beat(3'd7, 1'b0, 1'b1);
        check("w1_valid",    8'(a.out_valid), 8'h01);
        check("w1_in_ready", 8'(a.in_ready),  8'h00);
        check("w1_vec",      a.out_vec,       8'h89);
        check("w1_cnt",      8'(a.out_cnt),   8'h03);
        check("w1_err",      8'(a.out_err),   8'h00);
        consume();
        check("w1_done_valid", 8'(a.out_valid), 8'h00);
        check("w1_done_ready", 8'(a.in_ready),  8'h01);
        check("w1_retain_vec", a.out_vec,       8'h89);

        // Auto close at ACC_MAX
        beat(3'd1, 1'b0, 1'b0);
        beat(3'd2, 1'b0, 1'b0);
        beat(3'd4, 1'b0, 1'b0);
        check("w2_pre_valid", 8'(a.out_valid), 8'h00);
        beat(3'd5, 1'b0, 1'b0);
        check("w2_valid", 8'(a.out_valid), 8'h01);
        check("w2_vec",   a.out_vec,       8'h36);
        check("w2_cnt",   8'(a.out_cnt),   8'h04);
        check("w2_err",   8'(a.out_err),   8'h00);
        consume();

        // Duplicate code sets err; next word clears it
        beat(3'd2, 1'b0, 1'b0);
        beat(3'd2, 1'b0, 1'b1);
        check("w3_valid", 8'(a.out_valid), 8'h01);
        check("w3_vec",   a.out_vec,       8'h04);
        check("w3_cnt",   8'(a.out_cnt),   8'h02);
        check("w3_err",   8'(a.out_err),   8'h01);
        consume();
        beat(3'd6, 1'b0, 1'b1);
        check("w4_vec", a.out_vec,     8'h40);
        check("w4_cnt", 8'(a.out_cnt), 8'h01);
        check("w4_err", 8'(a.out_err), 8'h00);
        consume();

        // in_none beat, then backpressure with an offered beat that must not be taken
        beat(3'd5, 1'b1, 1'b1);
        a.in_valid = 1'b1; a.in_code = 3'd1; a.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    8'(a.out_valid), 8'h01);
            check("bp_in_ready", 8'(a.in_ready),  8'h00);
            check("bp_vec",      a.out_vec,       8'h00);
            check("bp_cnt",      8'(a.out_cnt),   8'h01);
            check("bp_err",      8'(a.out_err),   8'h00);
            tick();
        end
        a.in_valid = 1'b0; a.in_last = 1'b0;
        check("bp_end_vec", a.out_vec, 8'h00);
        consume();

        // Partial word discarded by reset
        beat(3'd1, 1'b0, 1'b0);
        beat(3'd2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 8'(a.out_valid), 8'h00);
        check("mid_rst_ready", 8'(a.in_ready),  8'h01);
        check("mid_rst_cnt",   8'(a.out_cnt),   8'h00);
        beat(3'd4, 1'b0, 1'b1);
        check("w6_valid", 8'(a.out_valid), 8'h01);
        check("w6_vec",   a.out_vec,       8'h10);
        check("w6_cnt",   8'(a.out_cnt),   8'h01);
        check("w6_err",   8'(a.out_err),   8'h00);
        consume();
        tick(); tick();
        check("w6_no_extra", 8'(a.out_valid), 8'h00);

        // ACC_MAX=1 stream with continuous in_valid and out_ready
        b.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_vec;
            exp_vec = 8'h01 << i;
            b.in_code = 3'(i);
            check("s_ready",  8'(b.in_ready), 8'h01);
            tick();
            check("s_valid",  8'(b.out_valid), 8'h01);
            check("s_vec",    b.out_vec,       exp_vec);
            check("s_cnt",    8'(b.out_cnt),   8'h01);
            check("s_busy",   8'(b.in_ready),  8'h00);
            tick();
            check("s_gap",    8'(b.out_valid), 8'h00);
        end
        b.in_valid = 1'b0;
        check("s_last_vec", b.out_vec, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
